// File: rtl/tim_apb_master_if.sv
// Command/response port plus APB4 bus seen by tim_apb_master.
// The master modport is the initiator's view; slave is the environment's view.
interface tim_apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  tim_psel;
  logic                  tim_penable;
  logic                  tim_pwrite;
  logic [ADDR_W-1:0]     tim_paddr;
  logic [DATA_W-1:0]     tim_pwdata;
  logic [DATA_W/8-1:0]   tim_pstrb;
  logic [DATA_W-1:0]     tim_prdata;
  logic                  tim_pready;
  logic                  tim_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  tim_prdata, tim_pready, tim_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output tim_prdata, tim_pready, tim_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );
endinterface

// File: rtl/tim_apb_master.sv
// Single-beat APB4 initiator toward timer_top with a wait-state timeout.
// One command in flight; a one-cycle rsp_valid strobe reports completion.
module tim_apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  tim_apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t                state;
  logic [7:0]            wait_cnt;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [DATA_W/8-1:0]   pstrb_q;
  logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0]     rsp_rdata_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state    <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            // Reads never present byte strobes on the bus.
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
          wait_cnt  <= '0;
        end
        ACCESS: begin
          if (bus.tim_pready) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.tim_pslverr;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.tim_prdata;
            rsp_timeout_q <= 1'b0;
          end else if (TO_EN && (wait_cnt == TO_LAST)) begin
            // Slave stalled for TIMEOUT ACCESS cycles: abandon the transfer.
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.tim_psel    = psel_q;
  assign bus.tim_penable = penable_q;
  assign bus.tim_pwrite  = pwrite_q;
  assign bus.tim_paddr   = paddr_q;
  assign bus.tim_pwdata  = pwdata_q;
  assign bus.tim_pstrb   = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_tim_apb_master.sv
// Randomized bench for tim_apb_master: a transaction-level model predicts the
// cycle shape and response of every transfer from the slave's wait behaviour.
module tb_tim_apb_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  int   n_checks  = 0;
  int   n_fail    = 0;

  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;
  logic        last_to    = 1'b0;

  tim_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  tim_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One transfer, called at a falling edge while the master is idle. The slave
  // answers after 'waits' wait states; waits >= TO means it never answers.
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, input int waits, input logic serr,
                      input logic [31:0] rd);
    logic        to_exp;
    int          n_pen;
    int          n;
    int          acc;
    int          errs;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sb;
    to_exp = (waits >= TO);
    n_pen  = to_exp ? TO : waits + 1;
    n      = n_pen + 2;
    acc    = 0;
    errs   = 0;
    exp_rd = (to_exp || wr) ? 32'h0 : rd;
    exp_sb = wr ? sb : 4'h0;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = sb;
    chk("cmd_ready_before", 32'(bus.cmd_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = 12'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);

    for (int k = 1; k <= n; k++) begin
      @(negedge sys_clk);
      if (bus.tim_psel    !== (k < n))            errs++;
      if (bus.tim_penable !== (k >= 2 && k < n))  errs++;
      if (bus.rsp_valid   !== (k == n))           errs++;
      if (bus.cmd_ready   !== (k == n))           errs++;
      if (k < n && (bus.tim_paddr !== a || bus.tim_pwrite !== wr ||
                    bus.tim_pwdata !== wd || bus.tim_pstrb !== exp_sb)) errs++;
      if (k == n) break;
      if (bus.tim_penable === 1'b1) begin
        acc++;
        bus.tim_pready = (acc == waits + 1);
      end else begin
        bus.tim_pready = 1'($urandom);
      end
      if (bus.tim_pready && bus.tim_penable) begin
        bus.tim_prdata  = rd;
        bus.tim_pslverr = serr;
      end else begin
        bus.tim_prdata  = $urandom;
        bus.tim_pslverr = 1'($urandom);
      end
    end
    chk("timing", 32'(errs), 32'd0);
    chk("access_cycles", 32'(acc), 32'(n_pen));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(to_exp | serr));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(to_exp));
    last_rdata = exp_rd;
    last_err   = to_exp | serr;
    last_to    = to_exp;
  endtask

  // Idle cycles: no strobe, bus parked, response fields held.
  task automatic idle(input int cycles);
    int errs;
    errs = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      if (bus.rsp_valid !== 1'b0 || bus.tim_psel !== 1'b0 || bus.cmd_ready !== 1'b1) errs++;
      if (bus.rsp_rdata !== last_rdata || bus.rsp_err !== last_err ||
          bus.rsp_timeout !== last_to) errs++;
      bus.tim_pready = 1'($urandom);
    end
    if (cycles > 0) chk("idle_hold", 32'(errs), 32'd0);
  endtask

  initial begin
    int rv_seen;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.cmd_strb    = '0;
    bus.tim_prdata  = '0;
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;

    #1 sys_rst_n = 1'b0;
    #2;
    chk("rst_psel", 32'(bus.tim_psel), 32'd0);
    chk("rst_outputs", 32'(|{bus.tim_penable, bus.tim_pwrite, bus.tim_paddr, bus.tim_pwdata,
                             bus.tim_pstrb, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                             bus.rsp_timeout}), 32'd0);
    @(negedge sys_clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    sys_rst_n = 1'b1;

    xfer(1'b1, 12'h000, 32'h0000_0101, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    xfer(1'b0, 12'h004, 32'h0, 4'hF, 2, 1'b0, 32'h1234_5678);
    idle(1);
    xfer(1'b1, 12'hFFC, 32'hA5A5_5A5A, 4'h3, 0, 1'b1, 32'h0);
    idle(1);
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 99, 1'b0, 32'hCAFE_F00D);
    idle(2);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 1, 1'b0, 32'h1111_2222);
    xfer(1'b0, 12'h00C, 32'h0, 4'h0, 0, 1'b0, 32'h3333_4444);
    idle(1);

    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), 12'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 5)),
           1'($urandom_range(0, 3) == 0), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    // Make the held response nonzero so the reset clear below is observable.
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b0, 32'h8765_4321);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 12'h024;
    bus.cmd_wdata = 32'h5555_AAAA;
    bus.cmd_strb  = 4'hF;
    @(posedge sys_clk);
    #1 bus.cmd_valid = 1'b0;
    bus.tim_pready = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("pre_rst_penable", 32'(bus.tim_penable), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_psel", 32'(bus.tim_psel), 32'd0);
    chk("midrst_penable", 32'(bus.tim_penable), 32'd0);
    chk("midrst_outputs", 32'(|{bus.tim_pwrite, bus.tim_paddr, bus.tim_pwdata, bus.tim_pstrb,
                                bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}),
        32'd0);
    rv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      if (bus.rsp_valid !== 1'b0) rv_seen++;
      bus.tim_pready = 1'b1;
    end
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      if (bus.rsp_valid !== 1'b0 || bus.tim_psel !== 1'b0) rv_seen++;
    end
    chk("midrst_no_rsp", 32'(rv_seen), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    last_rdata = '0;
    last_err   = 1'b0;
    last_to    = 1'b0;
    xfer(1'b1, 12'h028, 32'h0BAD_F00D, 4'h5, 1, 1'b0, 32'h0);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tim_apb_master.md
# tim_apb_master

APB initiator that turns single-beat commands from an internal command port into APB4 transfers toward `timer_top`. It drives the `tim_*` bus signals, holds them through SETUP/ACCESS, waits on `tim_pready`, and returns read data and error status on a one-cycle response strobe. It adds a programmable wait-state timeout so that a slave which never responds cannot hang the caller.

## Interface
Parameters:
- `ADDR_W`, 12, APB address width
- `DATA_W`, 32, APB data width; `DATA_W/8` strobe bits
- `TIMEOUT`, 255, maximum ACCESS cycles before abort; 0 disables the timeout; legal range 0..255

Ports:
- `sys_clk`  in  1  single clock; all logic on the rising edge
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a clock edge
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data
- `cmd_strb`  in  DATA_W/8  write byte strobes
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and timeouts
- `rsp_err`  out  1  `tim_pslverr` was sampled high, or a timeout occurred
- `rsp_timeout`  out  1  transfer was aborted by the timeout
- `tim_psel`, `tim_penable`, `tim_pwrite`  out  1  APB control
- `tim_paddr`  out  ADDR_W  APB address
- `tim_pwdata`  out  DATA_W  APB write data
- `tim_pstrb`  out  DATA_W/8  APB strobes
- `tim_prdata`  in  DATA_W  APB read data
- `tim_pready`  in  1  APB ready
- `tim_pslverr`  in  1  APB slave error

## Operation
- FSM states:
  - IDLE: `psel=0`, `penable=0`.
  - SETUP: `psel=1`, `penable=0`.
  - ACCESS: `psel=1`, `penable=1`.
- All APB outputs and all `rsp_*` outputs are registered.
- `cmd_ready` = (state == IDLE).
- IDLE → SETUP on accept. At the accept edge, `tim_paddr`, `tim_pwrite` and `tim_pwdata` are loaded from `cmd_*`. `tim_pstrb` is loaded with `cmd_strb` for writes and forced to 0 for reads.
- SETUP → ACCESS unconditionally after one cycle. The wait counter clears on entering ACCESS.
- ACCESS with `tim_pready=1` at an edge:
  - go to IDLE;
  - `rsp_valid=1` for the next cycle;
  - `rsp_err = tim_pslverr`;
  - `rsp_rdata = tim_prdata` for reads, 0 for writes;
  - `rsp_timeout=0`.
- ACCESS with `tim_pready=0`: the counter increments. If `TIMEOUT!=0` and the counter equals `TIMEOUT-1` at that edge, the FSM aborts to IDLE with `rsp_valid=1`, `rsp_err=1`, `rsp_timeout=1` and `rsp_rdata=0`. ACCESS therefore lasts exactly `TIMEOUT` cycles.
- `tim_prdata` and `tim_pslverr` are sampled only on the completing edge.
- Address, data, write and strobe stay stable from SETUP through the completing edge. In IDLE they hold their last values.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` hold their values until the next response. Only `rsp_valid` is a pulse.
- Back-to-back transfers: the IDLE cycle that carries `rsp_valid` also has `cmd_ready=1`. A command accepted there enters SETUP next, so `tim_psel` is low for exactly one cycle between transfers.
- `cmd_*` inputs are ignored outside the accept edge.

## Timing
- Reset (asynchronous, immediate): state = IDLE, counter = 0, and every output is 0 (`tim_*`, `rsp_*`). `cmd_ready` becomes 1 once the state is IDLE.
- Reset mid-transfer drops `psel`/`penable` at once and produces no response. The aborted command is lost.
- Latency with zero wait states: accept at edge E0 → SETUP in cycle 1 → ACCESS in cycle 2 → sample at E2 → `rsp_valid` in cycle 3.
- Each slave wait state adds one cycle.
- Throughput is at most one transfer per 3 cycles.
- `tim_pready` is ignored in IDLE and SETUP.

## Test plan
- Zero-wait write: write 0x000, data 0x0000_0101, strb 0xF, `pready` tied 1. Required: `psel` high cycles 1–2, `penable` high cycle 2 only, `rsp_valid` in cycle 3, `rsp_err=0`, `rsp_rdata=0`.
- Wait-state read: read 0x004; the slave returns `pready` after 2 wait states with `prdata` 0x1234_5678. Required: ACCESS spans 3 cycles, `rsp_valid` in cycle 5 with `rsp_rdata=0x1234_5678`, and `tim_pstrb=0` throughout.
- Slave error: write 0xFFC and the slave asserts `pslverr` with `pready`. Required: `rsp_err=1`, `rsp_timeout=0`, and the FSM returns to IDLE.
- Timeout: run with `TIMEOUT=4` and `pready` held 0. Required: `penable` high exactly 4 cycles, then `psel`/`penable` drop; `rsp_valid` with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
- Back-to-back: hold `cmd_valid` for two reads (0x008, 0x00C). Required: the second is accepted in the first's `rsp_valid` cycle, `psel` is low for exactly 1 cycle between them, and both responses are correct.
- Reset mid-ACCESS: assert `sys_rst_n=0` while `penable=1`. Required: all outputs are 0 immediately, no `rsp_valid`, and after release `cmd_ready=1` and a new write completes normally.
